// File: rtl/tx_sched_pkg.sv
// Shared constants and types for the UART transmit scheduler.
// Defining TX_CHECKSUM_EN appends an XOR checksum byte to every frame.
package tx_sched_pkg;

   localparam logic [7:0] OP_KEY    = 8'h01;
   localparam logic [7:0] OP_BUY    = 8'h02;
   localparam logic [7:0] OP_SELL   = 8'h03;
   localparam logic [7:0] OP_CLOSE  = 8'h04;
   localparam logic [7:0] PAIR_BASE = 8'h01;

`ifdef TX_CHECKSUM_EN
   localparam int FRAME_LEN = 3;
`else
   localparam int FRAME_LEN = 2;
`endif
   localparam int IDX_W = (FRAME_LEN > 2) ? 2 : 1;

   typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
   typedef enum logic {KEY, ORDER} req_t;

   // Coinciding order pulses resolve to the most defensive action.
   function automatic logic [7:0] order_op(input logic buy, input logic sell, input logic close);
      if (close)     return OP_CLOSE;
      else if (sell) return OP_SELL;
      else           return OP_BUY;
   endfunction

endpackage

// File: rtl/tx_req_slot.sv
// One-deep request holder: pending flag plus payload; a new request in the
// grant cycle is kept, a request onto an occupied slot is dropped.
module tx_req_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         set,
   input  logic         clr,
   input  logic [W-1:0] din,
   output logic         pending,
   output logic [W-1:0] payload,
   output logic         drop
);

   assign drop = set & pending & ~clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
         payload <= '0;
      end else if (set && (!pending || clr)) begin
         pending <= 1'b1;
         payload <= din;
      end else if (clr) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares the single UART transmitter between the keyboard and order buttons,
// issuing fixed-length frames byte by byte. Build option: TX_CHECKSUM_EN.
module uart_tx_scheduler
   import tx_sched_pkg::*;
#(
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [7:0] key_ascii,
   input  logic       buy,
   input  logic       sell,
   input  logic       close,
   input  logic       pair,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_done,
   output logic       busy,
   output logic [7:0] drop_cnt,
   output logic       timeout_err
);

   localparam int CNT_MAX  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_t     state, state_nx;
   req_t       last_grant;
   logic       key_pend, ord_pend, key_drop, ord_drop;
   logic       grant_key, grant_ord;
   logic [7:0] key_pl;
   logic [8:0] ord_pl;
   logic [7:0] b0, b1;
   logic [8:0] drop_sum;
   logic [FRAME_LEN-1:0][7:0] frame_q, frame_nx;
   logic [IDX_W-1:0] idx;
   logic             last_q;
   logic [CNT_W-1:0] cnt;
   logic             to_hit, gap_hit;

   tx_req_slot #(.W(8)) u_key_slot (
      .clk(clk), .rst(rst), .set(key_valid), .clr(grant_key), .din(key_ascii),
      .pending(key_pend), .payload(key_pl), .drop(key_drop)
   );

   tx_req_slot #(.W(9)) u_ord_slot (
      .clk(clk), .rst(rst), .set(buy | sell | close), .clr(grant_ord),
      .din({pair, order_op(buy, sell, close)}),
      .pending(ord_pend), .payload(ord_pl), .drop(ord_drop)
   );

   assign to_hit  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign gap_hit = (cnt == CNT_W'(GAP_LAST));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (grant_key || grant_ord) state_nx = START;
         START:   state_nx = WAIT;
         WAIT:    if (tx_done) state_nx = GAP;
                  else if (to_hit) state_nx = IDLE;
         GAP:     if (gap_hit) state_nx = last_q ? IDLE : START;
         default: state_nx = IDLE;
      endcase
   end

   // Round-robin only matters when both slots wait: favour the one not served last.
   always_comb begin
      busy      = (state != IDLE);
      tx_start  = (state == START);
      grant_ord = (state == IDLE) && ord_pend && (!key_pend || last_grant == KEY);
      grant_key = (state == IDLE) && key_pend && !grant_ord;
   end

   always_comb begin
      b0 = grant_ord ? ord_pl[7:0] : OP_KEY;
      b1 = grant_ord ? PAIR_BASE + {7'd0, ord_pl[8]} : key_pl;
      frame_nx    = '0;
      frame_nx[0] = b0;
      frame_nx[1] = b1;
`ifdef TX_CHECKSUM_EN
      frame_nx[2] = b0 ^ b1;
`endif
   end

   assign drop_sum = {1'b0, drop_cnt} + {8'd0, key_drop} + {8'd0, ord_drop};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_data     <= '0;
         frame_q     <= '0;
         idx         <= '0;
         last_q      <= 1'b0;
         cnt         <= '0;
         last_grant  <= KEY;
         timeout_err <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
         case (state)
            IDLE: if (grant_key || grant_ord) begin
               frame_q    <= frame_nx;
               tx_data    <= frame_nx[0];
               idx        <= '0;
               last_q     <= 1'b0;
               last_grant <= grant_ord ? ORDER : KEY;
            end
            START: cnt <= '0;
            WAIT: begin
               if (tx_done) begin
                  cnt <= '0;
                  if (idx == LAST_IDX) last_q <= 1'b1;
                  else                 idx    <= idx + 1'b1;
               end else if (to_hit) begin
                  timeout_err <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (gap_hit) begin
                  cnt <= '0;
                  if (!last_q) tx_data <= frame_q[idx];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Sequences all outbound traffic onto the single UART transmitter and shares it between two requesters: the keyboard path (ASCII bytes) and the order buttons (buy/sell/close plus pair select).
- Each request becomes a fixed-length frame. Bytes are issued one at a time with a start/done handshake, an optional inter-byte gap, and a per-byte timeout.
- Sits between the debounce/one-pulse and key-decode logic and the uart_tx instance. It replaces free-running trigger logic.

Parameters:
- GAP_CYCLES, 16, idle clk cycles between consecutive bytes and between frames (0 = no gap).
- TIMEOUT_CYCLES, 2_000_000, max clk cycles to wait for tx_done per byte before aborting the frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle pulse: new key press
- key_ascii  in  8  ASCII code, valid with key_valid
- buy  in  1  one-cycle pulse
- sell  in  1  one-cycle pulse
- close  in  1  one-cycle pulse
- pair  in  1  pair select, sampled with any order pulse
- tx_data  out  8  byte to uart_tx, stable from tx_start until tx_done
- tx_start  out  1  one-cycle start pulse to uart_tx
- tx_done  in  1  one-cycle completion pulse from uart_tx
- busy  out  1  high whenever state != IDLE
- drop_cnt  out  8  saturating count of dropped requests
- timeout_err  out  1  sticky; set on any byte timeout

Behaviour:
- Reset (async, active-high) forces all outputs to 0, clears both pending slots, sets state to IDLE and sets last_grant to KEY.
- A reset mid-frame abandons the frame immediately; tx_start drops in the same instant.
- Each requester owns one pending slot.
  - Key slot stores key_ascii.
  - Order slot stores opcode and pair.
  - Opcode when order pulses coincide: close 0x04 > sell 0x03 > buy 0x02.
- A pulse arriving while the slot is already pending is dropped and drop_cnt increments. drop_cnt saturates at 255.
- If a pulse arrives in the same cycle the slot is granted, the new request is kept: set wins over clear.
- Frames:
  - Key frame: [0x01, ascii].
  - Order frame: [opcode, 0x01 + pair].
- Arbitration is round-robin, evaluated in IDLE only.
  - If both slots are pending, grant the one not equal to last_grant.
  - If only one is pending, grant it.
  - last_grant updates on every grant.
- States and transitions:
  - IDLE: on grant, copy the frame into byte registers, clear the slot, set idx=0, go to START.
  - START: tx_start=1 for exactly one cycle, tx_data=byte[idx], go to WAIT.
  - WAIT: hold tx_data and count cycles.
    - On tx_done: if idx==LEN-1, go to GAP with done flag; otherwise idx++ and go to GAP.
    - If the count reaches TIMEOUT_CYCLES: set timeout_err, discard the rest of the frame, go to IDLE.
  - GAP: count GAP_CYCLES, then go to START (mid-frame) or IDLE (frame done). With GAP_CYCLES=0, GAP lasts exactly 1 cycle.
- tx_done outside WAIT is ignored.
- Latency: a request pulse sampled at edge N gives pending at N; a START decision at N+1; tx_start high during cycle N+1→N+2.
- tx_data holds its last value while in IDLE.

Optional Feature:
- Macro TX_CHECKSUM_EN.
- Defined: each frame gets a third byte, the XOR of bytes 0 and 1, so LEN=3. Example: key 'A' gives 0x01, 0x41, 0x40.
- Undefined: LEN=2 and no checksum logic is generated.

Decomposition:
- Shared package tx_sched_pkg holds:
  - opcode constants OP_KEY=0x01, OP_BUY=0x02, OP_SELL=0x03, OP_CLOSE=0x04, PAIR_BASE=0x01
  - state encoding IDLE/START/WAIT/GAP
  - requester ID encoding KEY/ORDER
  - FRAME_LEN, derived from TX_CHECKSUM_EN
- One sub-module, tx_req_slot: a pending flag plus payload register with set-wins-over-clear and a drop-pulse output. It is instantiated twice, and the top level sums the drop pulses into drop_cnt.

Test Plan:
- Key path: key_valid with ascii 0x41, and tx_done returned 10 cycles after each tx_start.
  - tx_start appears twice, with tx_data 0x01 then 0x41.
  - Consecutive tx_start pulses are separated by ≥GAP_CYCLES+1 idle cycles.
  - busy falls after the last gap.
- Order priority: buy and close pulse together with pair=1 → frame 0x04, 0x02; drop_cnt stays 0.
- Round-robin:
  - Key 0x61 and sell/pair=0 pulse together after reset → order frame (0x03, 0x01) first, then key frame (0x01, 0x61).
  - Repeat the same stimulus → frames alternate in the same way.
- Overflow: three key pulses (0x31, 0x32, 0x33) while the first frame is in WAIT → 0x31 is sent, 0x32 is kept, 0x33 is dropped, drop_cnt=1.
- Timeout: TIMEOUT_CYCLES=50 and tx_done never returned → timeout_err rises 50 cycles after tx_start; no second byte is sent; state returns to IDLE; the next request is still served.
- Reset mid-frame: assert rst during WAIT of byte 0 → all outputs 0 asynchronously and pending slots empty; after release, no residual tx_start occurs.
